// File: rtl/stage_sequencer_if.sv
// stage_sequencer_if: step-control inputs, memory handshake and status outputs
// of stage_sequencer, bundled into one port.
//   master : sequencer side - drives memReq, stage, stageAdv, insnCount,
//            stalled, halted; receives isAuto, nextStage, autoDiv, halt, memAck
//   slave  : datapath / environment side, opposite directions
// Optional macro STAGE_BREAK_EN adds breakCount (to sequencer) and breakHit
// (from sequencer).
interface stage_sequencer_if #(
  parameter int unsigned STAGE_W    = 3,
  parameter int unsigned AUTO_DIV_W = 24,
  parameter int unsigned CNT_W      = 16
);
  logic                  isAuto;
  logic                  nextStage;
  logic [AUTO_DIV_W-1:0] autoDiv;
  logic                  halt;
  logic                  memAck;
  logic                  memReq;
  logic [STAGE_W-1:0]    stage;
  logic                  stageAdv;
  logic [CNT_W-1:0]      insnCount;
  logic                  stalled;
  logic                  halted;
`ifdef STAGE_BREAK_EN
  logic [CNT_W-1:0]      breakCount;
  logic                  breakHit;

  modport master (
    input  isAuto, nextStage, autoDiv, halt, memAck, breakCount,
    output memReq, stage, stageAdv, insnCount, stalled, halted, breakHit
  );
  modport slave (
    output isAuto, nextStage, autoDiv, halt, memAck, breakCount,
    input  memReq, stage, stageAdv, insnCount, stalled, halted, breakHit
  );
`else
  modport master (
    input  isAuto, nextStage, autoDiv, halt, memAck,
    output memReq, stage, stageAdv, insnCount, stalled, halted
  );
  modport slave (
    output isAuto, nextStage, autoDiv, halt, memAck,
    input  memReq, stage, stageAdv, insnCount, stalled, halted
  );
`endif
endinterface

// File: rtl/stage_sequencer.sv
// stage_sequencer: multi-cycle stage controller for the CPU datapath.
// Steps the stage number 0..NUM_STAGES-1 either from a programmable auto
// divider or from a debounced single-step button, inserts memory wait states
// on stages flagged in MEM_STAGE_MASK, counts retired instructions and stops
// at an instruction boundary on halt.
// Ports:
//   clk    - system clock
//   rst_n  - synchronous active-low reset
//   bus    - stage_sequencer_if.master (mode/step inputs, memReq/memAck
//            handshake, stage/stageAdv/insnCount/stalled/halted status)
// Optional macro STAGE_BREAK_EN: instruction-count breakpoint for auto mode
// (breakCount input, breakHit output on the interface).
module stage_sequencer #(
  parameter int unsigned NUM_STAGES      = 5,
  parameter int unsigned STAGE_W         = 3,
  parameter logic [7:0]  MEM_STAGE_MASK  = 8'b0000_1001,
  parameter int unsigned AUTO_DIV_W      = 24,
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned CNT_W           = 16
) (
  input logic               clk,
  input logic               rst_n,
  stage_sequencer_if.master bus
);

  localparam int unsigned        DB_W       = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DB_W-1:0]    DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [STAGE_W-1:0] LAST_STAGE = STAGE_W'(NUM_STAGES - 1);

  typedef enum logic [1:0] {RUN, MEMWAIT, HALT} state_e;

  function automatic logic is_mem(input logic [STAGE_W-1:0] s);
    return |(MEM_STAGE_MASK & (8'd1 << s));
  endfunction

  state_e                state_q, state_d;
  logic                  sync1_q, sync1_d, sync2_q, sync2_d;
  logic [DB_W-1:0]       db_cnt_q, db_cnt_d;
  logic                  db_level_q, db_level_d;
  logic                  auto_prev_q, auto_prev_d;
  logic [AUTO_DIV_W-1:0] div_q, div_d;
  logic                  ack_seen_q, ack_seen_d;
  logic [STAGE_W-1:0]    stage_q, stage_d;
  logic                  stage_adv_q, stage_adv_d;
  logic [CNT_W-1:0]      insn_q, insn_d;
  logic                  stalled_q, stalled_d;
  logic                  halted_q, halted_d;
  logic                  mem_req_q, mem_req_d;
  logic                  btn_rise, mode_chg, auto_gate, step_req, advance;
`ifdef STAGE_BREAK_EN
  logic                  brk_q, brk_d;
`endif

  always_comb begin
    state_d     = state_q;
    stage_d     = stage_q;
    insn_d      = insn_q;
    ack_seen_d  = ack_seen_q;
    advance     = 1'b0;

    // Button: 2-flop synchroniser, then count samples that disagree with the
    // debounced level; any agreeing sample restarts the count.
    sync1_d    = bus.nextStage;
    sync2_d    = sync1_q;
    db_cnt_d   = '0;
    db_level_d = db_level_q;
    btn_rise   = 1'b0;
    if (sync2_q != db_level_q) begin
      if (db_cnt_q == DB_LAST) begin
        db_level_d = sync2_q;
        btn_rise   = sync2_q;
      end else begin
        db_cnt_d = db_cnt_q + DB_W'(1);
      end
    end

    auto_prev_d = bus.isAuto;
    mode_chg    = bus.isAuto != auto_prev_q;
`ifdef STAGE_BREAK_EN
    auto_gate = !brk_q;
`else
    auto_gate = 1'b1;
`endif

    step_req = 1'b0;
    if (!bus.isAuto || mode_chg) begin
      div_d = '0;
    end else if (div_q == bus.autoDiv) begin
      div_d    = '0;
      step_req = auto_gate;
    end else begin
      div_d = div_q + AUTO_DIV_W'(1);
    end
    if (!bus.isAuto && !mode_chg && btn_rise) begin
      step_req = 1'b1;
    end

    case (state_q)
      RUN: begin
        if (step_req) begin
          if (!is_mem(stage_q) || bus.memAck || ack_seen_q) begin
            advance = 1'b1;
          end else begin
            state_d = MEMWAIT;
          end
        end else if (bus.memAck) begin
          ack_seen_d = 1'b1;
        end
      end
      MEMWAIT: begin
        // Requests arriving here are dropped; a mode change abandons the step.
        if (mode_chg) begin
          state_d    = RUN;
          ack_seen_d = bus.memAck;
        end else if (bus.memAck) begin
          state_d = RUN;
          advance = 1'b1;
        end
      end
      default: ;
    endcase

    stage_adv_d = advance;
    if (advance) begin
      ack_seen_d = 1'b0;
      if (stage_q == LAST_STAGE) begin
        stage_d = '0;
        insn_d  = insn_q + CNT_W'(1);
        if (bus.halt) begin
          state_d = HALT;
        end
      end else begin
        stage_d = stage_q + STAGE_W'(1);
      end
    end

`ifdef STAGE_BREAK_EN
    brk_d = brk_q;
    if (!bus.isAuto) begin
      brk_d = 1'b0;
    end else if (advance && stage_q == LAST_STAGE && insn_d == bus.breakCount) begin
      brk_d = 1'b1;
    end
`endif

    stalled_d = state_d == MEMWAIT;
    halted_d  = state_d == HALT;
    mem_req_d = (state_d != HALT) && is_mem(stage_d);
  end

  always_ff @(posedge clk) begin
    // Tracked through reset so releasing reset is not seen as a mode change.
    auto_prev_q <= auto_prev_d;
    if (!rst_n) begin
      state_q     <= RUN;
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      db_cnt_q    <= '0;
      db_level_q  <= 1'b0;
      div_q       <= '0;
      ack_seen_q  <= 1'b0;
      stage_q     <= '0;
      stage_adv_q <= 1'b0;
      insn_q      <= '0;
      stalled_q   <= 1'b0;
      halted_q    <= 1'b0;
      mem_req_q   <= 1'b0;
`ifdef STAGE_BREAK_EN
      brk_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      db_cnt_q    <= db_cnt_d;
      db_level_q  <= db_level_d;
      div_q       <= div_d;
      ack_seen_q  <= ack_seen_d;
      stage_q     <= stage_d;
      stage_adv_q <= stage_adv_d;
      insn_q      <= insn_d;
      stalled_q   <= stalled_d;
      halted_q    <= halted_d;
      mem_req_q   <= mem_req_d;
`ifdef STAGE_BREAK_EN
      brk_q       <= brk_d;
`endif
    end
  end

  assign bus.memReq    = mem_req_q & is_mem(stage_q);
  assign bus.stage     = stage_q;
  assign bus.stageAdv  = stage_adv_q;
  assign bus.insnCount = insn_q;
  assign bus.stalled   = stalled_q;
  assign bus.halted    = halted_q;
`ifdef STAGE_BREAK_EN
  assign bus.breakHit  = brk_q;
`endif

endmodule

// File: tb/tb_stage_sequencer.sv
// Testbench for stage_sequencer: directed stimulus, a cycle-level reference
// model of the sequencing rules checked every cycle, plus literal checks.
module tb_stage_sequencer;
  localparam int unsigned NS  = 5;
  localparam int unsigned SW  = 3;
  localparam int unsigned ADW = 24;
  localparam int unsigned DB  = 16;
  localparam int unsigned CW  = 16;
  localparam logic [7:0]  MASK = 8'b0000_1001;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  stage_sequencer_if #(.STAGE_W(SW), .AUTO_DIV_W(ADW), .CNT_W(CW)) sif ();

  stage_sequencer #(
    .NUM_STAGES(NS), .STAGE_W(SW), .MEM_STAGE_MASK(MASK),
    .AUTO_DIV_W(ADW), .DEBOUNCE_CYCLES(DB), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(sif)
  );

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;
  int seq5 [5] = '{1, 2, 3, 4, 0};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    tick(n);
    rst_n = 1'b1;
  endtask

  function automatic bit mem_stage(input int s);
    return ((MASK >> s) & 8'd1) != 8'd0;
  endfunction

  // Reference model state
  int m_stage, m_insn, m_cyc, m_run, m_level, m_last_s, p0, p1;
  bit m_adv, m_wait, m_halt, m_memreq, m_ack, m_prev_auto, m_brk;

  always @(posedge clk) begin
    int s, a;
    bit rise, mode_chg, req, adv;
    if (!rst_n) begin
      m_stage = 0; m_insn = 0; m_cyc = 0; m_run = 0; m_level = 0; m_last_s = 0;
      p0 = 0; p1 = 0;
      m_adv = 0; m_wait = 0; m_halt = 0; m_memreq = 0; m_ack = 0; m_brk = 0;
      m_prev_auto = sif.isAuto;
    end else begin
      // debounced button: level follows after DB equal synchronised samples
      s = p1; p1 = p0; p0 = int'(sif.nextStage);
      if (s == m_last_s) m_run++; else m_run = 1;
      m_last_s = s;
      rise = 0;
      if (s != m_level && m_run >= DB) begin
        m_level = s;
        rise = (s == 1);
      end

      mode_chg = (sif.isAuto != m_prev_auto);
      m_prev_auto = sif.isAuto;
      a = int'(sif.autoDiv);
      req = 0;
      if (!sif.isAuto || mode_chg) begin
        m_cyc = 0;
      end else begin
        if ((m_cyc % (a + 1)) == a && !m_brk) req = 1;
        m_cyc++;
      end
      if (!sif.isAuto && !mode_chg && rise) req = 1;

      adv = 0;
      if (m_halt) begin
        adv = 0;
      end else if (m_wait) begin
        if (mode_chg) begin
          m_wait = 0;
          m_ack = sif.memAck;
        end else if (sif.memAck) begin
          adv = 1;
          m_wait = 0;
        end
      end else if (req) begin
        if (!mem_stage(m_stage) || sif.memAck || m_ack) adv = 1;
        else m_wait = 1;
      end else if (sif.memAck) begin
        m_ack = 1;
      end

      m_adv = adv;
      if (adv) begin
        m_ack = 0;
        m_stage++;
        if (m_stage == NS) begin
          m_stage = 0;
          m_insn = (m_insn + 1) % (1 << CW);
          if (sif.halt) m_halt = 1;
`ifdef STAGE_BREAK_EN
          if (sif.isAuto && m_insn == int'(sif.breakCount)) m_brk = 1;
`endif
        end
      end
      if (!sif.isAuto) m_brk = 0;
      m_memreq = !m_halt && mem_stage(m_stage);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("stage",     32'(sif.stage),     m_stage);
      chk("stageAdv",  32'(sif.stageAdv),  32'(m_adv));
      chk("insnCount", 32'(sif.insnCount), m_insn);
      chk("memReq",    32'(sif.memReq),    32'(m_memreq));
      chk("stalled",   32'(sif.stalled),   32'(m_wait));
      chk("halted",    32'(sif.halted),    32'(m_halt));
`ifdef STAGE_BREAK_EN
      chk("breakHit",  32'(sif.breakHit),  32'(m_brk));
`endif
    end
  end

  initial begin
    int first, advs;
    rst_n         = 1'b0;
    sif.isAuto    = 1'b1;
    sif.nextStage = 1'b0;
    sif.autoDiv   = 24'd3;
    sif.halt      = 1'b0;
    sif.memAck    = 1'b1;
`ifdef STAGE_BREAK_EN
    sif.breakCount = '1;
`endif

    // Reset held 3 cycles, then first step autoDiv+1 cycles after release
    tick(1);
    chk_en = 1'b1;
    tick(2);
    chk("rst_stage",  32'(sif.stage), 0);
    chk("rst_insn",   32'(sif.insnCount), 0);
    chk("rst_memreq", 32'(sif.memReq), 0);
    chk("rst_halted", 32'(sif.halted), 0);
    rst_n = 1'b1;
    tick(3);
    chk("first_step_not_yet", 32'(sif.stage), 0);
    tick(1);
    chk("first_step_stage", 32'(sif.stage), 1);
    chk("first_step_adv",   32'(sif.stageAdv), 1);

    // Auto, autoDiv=0, ack tied high: one stage per cycle
    sif.autoDiv = 24'd0;
    do_reset(2);
    for (int i = 0; i < 5; i++) begin
      tick(1);
      chk("div0_stage", 32'(sif.stage), 32'(seq5[i]));
      chk("div0_adv",   32'(sif.stageAdv), 1);
    end
    chk("div0_insn", 32'(sif.insnCount), 1);

    // Auto, autoDiv=3, memory wait on stage 3
    sif.autoDiv = 24'd3;
    do_reset(2);
    tick(12);
    chk("mw_enter_stage3", 32'(sif.stage), 3);
    sif.memAck = 1'b0;
    tick(9);
    chk("mw_held_stage", 32'(sif.stage), 3);
    chk("mw_stalled",    32'(sif.stalled), 1);
    chk("mw_memreq",     32'(sif.memReq), 1);
    sif.memAck = 1'b1;
    tick(1);
    chk("mw_ack_stage",   32'(sif.stage), 4);
    chk("mw_ack_stalled", 32'(sif.stalled), 0);
    sif.memAck = 1'b0;
    tick(1);
    chk("mw_dropped_req", 32'(sif.stage), 4);
    tick(1);
    chk("mw_next_step", 32'(sif.stage), 0);

    // Single-step with bouncing button
    sif.isAuto = 1'b0;
    sif.memAck = 1'b1;
    do_reset(2);
    tick(3);
    for (int i = 0; i < 6; i++) begin
      sif.nextStage = (i % 2 == 0);
      tick(1);
    end
    sif.nextStage = 1'b1;
    first = -1;
    advs  = 0;
    for (int k = 0; k < 40; k++) begin
      tick(1);
      if (sif.stageAdv) begin
        advs++;
        if (first < 0) first = k + 1;
      end
    end
    chk("btn_delay_in_window", 32'(first >= 17 && first <= 19), 1);
    chk("btn_one_advance",     32'(advs), 1);
    chk("btn_stage",           32'(sif.stage), 1);
    sif.nextStage = 1'b0;
    advs = 0;
    for (int k = 0; k < 30; k++) begin
      tick(1);
      if (sif.stageAdv) advs++;
    end
    chk("btn_release_no_adv", 32'(advs), 0);
    sif.nextStage = 1'b1;
    for (int k = 0; k < 30; k++) begin
      tick(1);
      if (sif.stageAdv) advs++;
    end
    chk("btn_repress_one_adv", 32'(advs), 1);
    chk("btn_repress_stage",   32'(sif.stage), 2);
    sif.nextStage = 1'b0;

    // Halt at the instruction boundary
    sif.isAuto  = 1'b1;
    sif.autoDiv = 24'd0;
    do_reset(2);
    tick(2);
    chk("halt_at_stage2", 32'(sif.stage), 2);
    sif.halt = 1'b1;
    tick(3);
    chk("halt_stage",  32'(sif.stage), 0);
    chk("halt_flag",   32'(sif.halted), 1);
    chk("halt_insn",   32'(sif.insnCount), 1);
    chk("halt_memreq", 32'(sif.memReq), 0);
    advs = 0;
    for (int k = 0; k < 100; k++) begin
      tick(1);
      if (sif.stageAdv) advs++;
    end
    chk("halt_no_adv", 32'(advs), 0);
    rst_n = 1'b0;
    tick(1);
    chk("halt_cleared", 32'(sif.halted), 0);
    sif.halt = 1'b0;
    rst_n = 1'b1;

`ifdef STAGE_BREAK_EN
    // Instruction-count breakpoint in auto mode
    sif.breakCount = 16'd2;
    do_reset(2);
    tick(10);
    chk("brk_stage", 32'(sif.stage), 0);
    chk("brk_insn",  32'(sif.insnCount), 2);
    chk("brk_hit",   32'(sif.breakHit), 1);
    tick(5);
    chk("brk_hold_stage", 32'(sif.stage), 0);
    sif.isAuto = 1'b0;
    tick(2);
    chk("brk_hit_clear", 32'(sif.breakHit), 0);
    sif.isAuto = 1'b1;
    tick(3);
    chk("brk_resume_stage", 32'(sif.stage), 2);
    sif.breakCount = '1;
`endif

    tick(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
